// File: rtl/hazard_controller.sv
// Pipeline hazard / stall sequencer: 3-slot destination scoreboard (EXE, MEM, WB),
// bubble/freeze/flush/stall outputs and a RUN/HAZ/MEMWAIT FSM. Optional macro: FORWARDING_EN.
module hazard_controller #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       id_src1,
  input  logic [3:0]       id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [3:0]       id_dest,
  input  logic             exe_branch_taken,
  input  logic             mem_access,
  input  logic             mem_ready,
  output logic             hazard,
  output logic             freeze,
  output logic             flush,
  output logic             stall_all,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    HAZ     = 2'b01,
    MEMWAIT = 2'b10
  } state_t;

  state_t cur_state, nxt_state;

  logic       exe_v, mem_v, wb_v;
  logic [3:0] exe_d, mem_d, wb_d;
  logic       exe_l, mem_l, wb_l;

  logic exe_match, mem_match, raw_hazard, bubble;

  assign exe_match = exe_v && ((id_use_src1 && (id_src1 == exe_d)) ||
                               (id_use_src2 && (id_src2 == exe_d)));
  assign mem_match = mem_v && ((id_use_src1 && (id_src1 == mem_d)) ||
                               (id_use_src2 && (id_src2 == mem_d)));

  // The WB slot never stalls: the register file writes before it is read.
`ifdef FORWARDING_EN
  assign raw_hazard = exe_match && exe_l;
`else
  assign raw_hazard = exe_match || mem_match;
`endif

  // Memory handshake: an access is pending in MEM while mem_access is high and
  // completes in the cycle mem_ready is high; until then the whole pipe holds.
  assign stall_all = rst && mem_access && !mem_ready;
  assign flush     = rst && !stall_all && exe_branch_taken;
  assign hazard    = rst && !stall_all && !exe_branch_taken && raw_hazard;
  assign freeze    = hazard;
  assign bubble    = flush || hazard;
  assign state     = cur_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exe_v <= 1'b0;
      exe_d <= 4'd0;
      exe_l <= 1'b0;
      mem_v <= 1'b0;
      mem_d <= 4'd0;
      mem_l <= 1'b0;
      wb_v  <= 1'b0;
      wb_d  <= 4'd0;
      wb_l  <= 1'b0;
    end else if (!stall_all) begin
      wb_v  <= mem_v;
      wb_d  <= mem_d;
      wb_l  <= mem_l;
      mem_v <= exe_v;
      mem_d <= exe_d;
      mem_l <= exe_l;
      exe_v <= bubble ? 1'b0 : id_wb_en;
      exe_d <= bubble ? 4'd0 : id_dest;
      exe_l <= bubble ? 1'b0 : id_mem_r_en;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      RUN: begin
        if (stall_all)   nxt_state = MEMWAIT;
        else if (hazard) nxt_state = HAZ;
        else             nxt_state = RUN;
      end
      HAZ: begin
        if (stall_all)   nxt_state = MEMWAIT;
        else if (hazard) nxt_state = HAZ;
        else             nxt_state = RUN;
      end
      MEMWAIT: begin
        if (stall_all)   nxt_state = MEMWAIT;
        else if (hazard) nxt_state = HAZ;
        else             nxt_state = RUN;
      end
      default: nxt_state = RUN;
    endcase
    // flush is already masked by stall_all, so a memory wait still wins.
    if (flush) nxt_state = RUN;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (hazard || stall_all) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush)               flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a per-cycle vector table plus a
// hand-written asynchronous-reset sequence. Honors FORWARDING_EN if defined.
module tb_hazard_controller;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam int CNT_W = 16;

  logic             clk;
  logic             rst;
  logic [3:0]       id_src1, id_src2, id_dest;
  logic             id_use_src1, id_use_src2, id_wb_en, id_mem_r_en;
  logic             exe_branch_taken, mem_access, mem_ready;
  logic             hazard, freeze, flush, stall_all;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  int tests = 0;
  int fails = 0;

  hazard_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2),
    .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
    .exe_branch_taken(exe_branch_taken), .mem_access(mem_access), .mem_ready(mem_ready),
    .hazard(hazard), .freeze(freeze), .flush(flush), .stall_all(stall_all),
    .state(state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] s1, s2, d;
    logic       u1, u2, wb, mr, br, ma, mrdy;
    logic       h, fl, sa;
    logic [1:0] st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(input logic [3:0] s1, input logic [3:0] s2,
                             input logic u1, input logic u2, input logic wb,
                             input logic mr, input logic [3:0] d, input logic br,
                             input logic ma, input logic mrdy, input logic h,
                             input logic fl, input logic sa, input logic [1:0] st);
    vec_t r;
    r.s1 = s1; r.s2 = s2; r.u1 = u1; r.u2 = u2; r.wb = wb; r.mr = mr; r.d = d;
    r.br = br; r.ma = ma; r.mrdy = mrdy; r.h = h; r.fl = fl; r.sa = sa; r.st = st;
    return r;
  endfunction

  function automatic vec_t idle();
    return v(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0,
             1'b0, 1'b0, 1'b0, 2'd0);
  endfunction

  // driver tasks
  task automatic drive(input vec_t r);
    id_src1 = r.s1; id_src2 = r.s2; id_use_src1 = r.u1; id_use_src2 = r.u2;
    id_wb_en = r.wb; id_mem_r_en = r.mr; id_dest = r.d;
    exe_branch_taken = r.br; mem_access = r.ma; mem_ready = r.mrdy;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    logic [CNT_W-1:0] exp_sc, exp_fc;
    logic [1:0] hz, hs;
    hz = FWD ? 2'd0 : 2'd1;
    hs = FWD ? 2'd0 : 2'd1;

    // reset release, idle
    for (int i = 0; i < 10; i++) vecs.push_back(idle());
    // ADD R1 then SUB reading R1
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 3, 0, 0, 0, hz[0], 0, 0, 0));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 3, 0, 0, 0, hz[0], 0, 0, hs));
    vecs.push_back(v(1, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, hs));
    for (int i = 0; i < 3; i++) vecs.push_back(idle());
    // LDR R2 then a reader of src2=2
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(0, 2, 0, 1, 1, 0, 4, 0, 0, 0, 1, 0, 0, 0));
    vecs.push_back(v(0, 2, 0, 1, 1, 0, 4, 0, 0, 0, hz[0], 0, 0, 1));
    vecs.push_back(v(0, 2, 0, 1, 1, 0, 4, 0, 0, 0, 0, 0, 0, hs));
    for (int i = 0; i < 3; i++) vecs.push_back(idle());
    // taken branch alongside a conflicting source; flushed ID load must not enter EXE
    vecs.push_back(v(0, 0, 0, 0, 1, 1, 5, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(5, 0, 1, 0, 1, 1, 6, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(v(0, 6, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) vecs.push_back(idle());
    // memory wait over a pending hazard; branch during the wait is suppressed
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 7, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 0, 1, 0, 0, 0, 1, 0));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 1, 1, 0, 0, 0, 1, 2));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 0, 1, 0, 0, 0, 1, 2));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 0, 1, 1, hz[0], 0, 0, 2));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 0, 0, 0, hz[0], 0, 0, hs));
    vecs.push_back(v(7, 0, 1, 0, 1, 0, 8, 0, 0, 0, 0, 0, 0, hs));
    vecs.push_back(idle());
    // flush while in HAZ returns to RUN
    vecs.push_back(v(0, 0, 0, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(v(9, 0, 1, 0, 1, 0, 10, 0, 0, 0, hz[0], 0, 0, 0));
    vecs.push_back(v(9, 0, 1, 0, 1, 0, 10, 1, 0, 0, 0, 1, 0, hs));
    for (int i = 0; i < 3; i++) vecs.push_back(idle());

    rst = 1'b0;
    drive(idle());
    repeat (3) @(posedge clk);
    #1;
    check("in_reset_state", 32'(state), 32'd0);
    check("in_reset_stall_cnt", 32'(stall_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    exp_sc = '0;
    exp_fc = '0;
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d_hazard", i), 32'(hazard), 32'(vecs[i].h));
      check($sformatf("row%0d_freeze", i), 32'(freeze), 32'(vecs[i].h));
      check($sformatf("row%0d_flush", i), 32'(flush), 32'(vecs[i].fl));
      check($sformatf("row%0d_stall_all", i), 32'(stall_all), 32'(vecs[i].sa));
      check($sformatf("row%0d_state", i), 32'(state), 32'(vecs[i].st));
      check($sformatf("row%0d_stall_cnt", i), 32'(stall_cnt), 32'(exp_sc));
      check($sformatf("row%0d_flush_cnt", i), 32'(flush_cnt), 32'(exp_fc));
      if (vecs[i].h || vecs[i].sa) exp_sc = exp_sc + 1'b1;
      if (vecs[i].fl) exp_fc = exp_fc + 1'b1;
    end

    // asynchronous reset in the middle of a stall
    @(posedge clk); #1;
    drive(v(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk); #1;
    drive(v(1, 0, 1, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("rst_seq_hazard_before", 32'(hazard), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_seq_state_before", 32'(state), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("rst_async_hazard", 32'(hazard), 32'd0);
    check("rst_async_freeze", 32'(freeze), 32'd0);
    check("rst_async_state", 32'(state), 32'd0);
    check("rst_async_stall_cnt", 32'(stall_cnt), 32'd0);
    check("rst_async_flush_cnt", 32'(flush_cnt), 32'd0);
    mem_access = 1'b1; mem_ready = 1'b0; exe_branch_taken = 1'b1;
    #1;
    check("rst_async_stall_all", 32'(stall_all), 32'd0);
    check("rst_async_flush", 32'(flush), 32'd0);
    mem_access = 1'b0; exe_branch_taken = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("post_rst_hazard_now", 32'(hazard), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_hazard", 32'(hazard), 32'd0);
    check("post_rst_state", 32'(state), 32'd0);
    check("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_controller.md
Name: hazard_controller

Overview:
- Pipeline hazard and stall sequencer for the 5-stage core.
- Keeps its own 3-slot scoreboard of in-flight destination registers (EXE, MEM, WB) and drives:
  - `hazard` into the ID stage, which gates ID control outputs to zero and selects the bubble;
  - `freeze` to the IF stage and the IF/ID register;
  - `flush` on a taken branch.
- Also sequences whole-pipeline stalls while data memory is not ready, and counts stall cycles.

Parameters:
- CNT_W, 16, width of the `stall_cnt` and `flush_cnt` performance counters.

Ports:
- clk  input  1  core clock; every register updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_src1  input  4  Rn of the instruction in ID.
- id_src2  input  4  second source (Rd for stores, Rm otherwise), same selection as the ID register-file read.
- id_use_src1  input  1  src1 is read (0 for MOV/MVN/B).
- id_use_src2  input  1  src2 is read (1 for register-operand data ops and for stores).
- id_wb_en  input  1  ID instruction writes a register (already condition-gated).
- id_mem_r_en  input  1  ID instruction is a load.
- id_dest  input  4  destination of the ID instruction.
- exe_branch_taken  input  1  the instruction in EXE is a taken branch.
- mem_access  input  1  the instruction in MEM performs a memory read or write.
- mem_ready  input  1  data memory completes this cycle.
- hazard  output  1  to ID stage: insert a bubble into ID/EX.
- freeze  output  1  hold PC and the IF/ID register.
- flush  output  1  clear IF/ID and ID/EX.
- stall_all  output  1  hold every pipeline register (memory wait).
- state  output  2  00 RUN, 01 HAZ, 10 MEMWAIT.
- stall_cnt  output  CNT_W  cycles with `hazard` or `stall_all` high.
- flush_cnt  output  CNT_W  number of flush cycles.

Behaviour:
- Scoreboard
  - Each slot holds {valid, dest[3:0], is_load} for EXE, MEM and WB.
  - On reset all slots are invalid.
- Match condition
  - `match(slot)` = slot.valid && ((id_use_src1 && id_src1 == slot.dest) || (id_use_src2 && id_src2 == slot.dest)).
  - WB slot matches never raise `hazard`: the register file writes before it is read in the same cycle.
- Output priority (combinational, highest first)
  1. `stall_all` = mem_access && !mem_ready. While it is high, `hazard`, `flush` and `freeze` are all 0.
  2. `flush` = exe_branch_taken. When high, `hazard` is 0 and `freeze` is 0.
  3. `hazard` = match(EXE) || match(MEM).
  4. `freeze` = `hazard`.
- Scoreboard update on the clock edge
  - stall_all: every slot holds.
  - Otherwise WB <= MEM and MEM <= EXE. EXE is loaded as follows:
    - on `flush` or `hazard`, EXE <= invalid (bubble);
    - otherwise EXE <= {id_wb_en, id_dest, id_mem_r_en}.
- FSM, registered, reset state RUN
  - RUN -> MEMWAIT when stall_all; RUN -> HAZ when hazard; otherwise stay in RUN.
  - HAZ -> MEMWAIT when stall_all; stay in HAZ while hazard; otherwise -> RUN.
  - MEMWAIT -> stay while stall_all; otherwise -> HAZ if hazard, else -> RUN.
  - A flush in any state forces the next state to RUN unless stall_all is high.
- Counters
  - Increment by 1 each cycle that the condition holds; they wrap at 2^CNT_W.
  - `flush_cnt` increments on each cycle `flush` is high.
- Reset
  - Reset asserted mid-operation immediately clears all slots, the FSM, the counters and every output.
  - After reset, all outputs are 0 until the first conflicting ID input.
- A back-to-back dependency on a non-load stalls exactly 2 cycles. The bubble leaves EXE, the producer leaves MEM, then the instruction issues.

Optional Feature:
- FORWARDING_EN.
- Defined: `hazard` = match(EXE) && EXE.is_load; MEM-slot matches are ignored. A load-use dependency stalls exactly 1 cycle; ALU dependencies never stall. The EXE-stage forwarding unit resolves all other dependencies.
- Undefined: the behaviour is exactly as described in Behaviour above.

Test Plan:
- Reset release, ID inputs idle, 10 cycles -> hazard=freeze=flush=stall_all=0, state=00, stall_cnt=0.
- ADD R1 issued (id_wb_en=1, id_dest=1), next cycle SUB reads src1=1, id_use_src1=1 -> hazard=1 for exactly 2 cycles, then 0; stall_cnt=2. With FORWARDING_EN, hazard stays 0.
- LDR R2 issued (id_mem_r_en=1), next cycle instruction reads src2=2 -> with FORWARDING_EN, hazard=1 for exactly 1 cycle and state goes HAZ then RUN.
- exe_branch_taken=1 in the same cycle as a conflicting ID source -> flush=1, hazard=0; next cycle EXE slot invalid, flush_cnt=1.
- mem_access=1, mem_ready=0 for 3 cycles while an ID hazard is pending -> stall_all=1 and state=10 for 3 cycles, scoreboard frozen, hazard=0; on mem_ready=1 the hazard resumes and stall_cnt grows by 3 plus the remaining hazard cycles.
- rst pulled low in the middle of the 2-cycle stall -> all outputs 0 asynchronously; after release, the same ID inputs produce no hazard because the scoreboard is empty.
